// File: rtl/text_console_writer.sv
// Character-stream front end for the text overlay: converts ASCII/control bytes
// into single-cell buffer writes, tracking a cursor and running row/screen clears.
module text_console_writer #(
  parameter int         COLS      = 32,
  parameter int         ROWS      = 16,
  parameter logic [7:0] FILL_CHAR = 8'h00,
  parameter int         TAB_STOP  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wen,
  output logic [9:0] write_addr,
  output logic [7:0] write_data,
  output logic [7:0] cursor_col,
  output logic [7:0] cursor_row,
  output logic       busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLR_ROW = 2'd1;
  localparam logic [1:0] CLR_SCR = 2'd2;

  localparam logic [7:0]  COL_MAX   = 8'(COLS - 1);
  localparam logic [7:0]  ROW_MAX   = 8'(ROWS - 1);
  localparam logic [10:0] ROW_CELLS = 11'(COLS);
  localparam logic [10:0] SCR_CELLS = 11'(COLS * ROWS);
  localparam logic [8:0]  TAB_MASK  = 9'(TAB_STOP - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [10:0] cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        in_ready_q, in_ready_d;

  logic        accept;
  logic [7:0]  row_next;
  logic [8:0]  tab_next;

  function automatic logic [9:0] cell_addr(input logic [7:0] row, input logic [10:0] col);
    return 10'(19'(row) * 19'(COLS) + 19'(col));
  endfunction

  // cnt_q is the index of the next clear write; a clear state ends one cycle
  // after its last write so busy/in_ready cover every clear write cycle.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    accept   = in_valid & in_ready_q;
    row_next = (row_q == ROW_MAX) ? 8'd0 : row_q + 8'd1;
    tab_next = ({1'b0, col_q} | TAB_MASK) + 9'd1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wen_d  = 1'b1;
            addr_d = cell_addr(row_q, 11'(col_q));
            data_d = in_data;
            if (col_q < COL_MAX) begin
              col_d = col_q + 8'd1;
            end else begin
              // Auto-wrap: the character write goes first, the row clear follows.
              col_d   = '0;
              row_d   = row_next;
              state_d = CLR_ROW;
              cnt_d   = '0;
            end
          end else begin
            case (in_data)
              8'h0D: col_d = '0;
              8'h0A: begin
                row_d   = row_next;
                state_d = CLR_ROW;
                wen_d   = 1'b1;
                addr_d  = cell_addr(row_next, 11'd0);
                data_d  = FILL_CHAR;
                cnt_d   = 11'd1;
              end
              8'h08: begin
                if (col_q != 8'd0) begin
                  col_d  = col_q - 8'd1;
                  wen_d  = 1'b1;
                  addr_d = cell_addr(row_q, 11'(col_q - 8'd1));
                  data_d = FILL_CHAR;
                end
              end
              8'h09: col_d = (tab_next > {1'b0, COL_MAX}) ? COL_MAX : tab_next[7:0];
              8'h0C: begin
                col_d   = '0;
                row_d   = '0;
                state_d = CLR_SCR;
                wen_d   = 1'b1;
                addr_d  = '0;
                data_d  = FILL_CHAR;
                cnt_d   = 11'd1;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_ROW: begin
        if (cnt_q == ROW_CELLS) begin
          state_d = IDLE;
        end else begin
          wen_d  = 1'b1;
          addr_d = cell_addr(row_q, cnt_q);
          data_d = FILL_CHAR;
          cnt_d  = cnt_q + 11'd1;
        end
      end
      CLR_SCR: begin
        if (cnt_q == SCR_CELLS) begin
          state_d = IDLE;
        end else begin
          wen_d  = 1'b1;
          addr_d = cnt_q[9:0];
          data_d = FILL_CHAR;
          cnt_d  = cnt_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wen        = wen_q;
  assign write_addr = addr_q;
  assign write_data = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = (state_q == CLR_ROW) || (state_q == CLR_SCR);

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: cursor control codes, wrap, clears,
// back-pressure and reset during a screen clear.
module tb_text_console_writer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wen;
  logic [9:0] write_addr;
  logic [7:0] write_data;
  logic [7:0] cursor_col;
  logic [7:0] cursor_row;
  logic       busy;

  int total;
  int bad;

  text_console_writer #(
    .COLS(32),
    .ROWS(16),
    .FILL_CHAR(8'h00),
    .TAB_STOP(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wen(wen),
    .write_addr(write_addr),
    .write_data(write_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_idle: in_ready=%b expected 1 within 2000 cycles", in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #2;
    total++;
    if ({wen, write_addr, write_data} !== 19'd0) begin
      bad++;
      $display("FAIL reset_write: wen=%b addr=%0d data=%0h expected 0/0/0", wen, write_addr, write_data);
    end
    total++;
    if ({cursor_row, cursor_col} !== 16'd0) begin
      bad++;
      $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col);
    end
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b busy=%b expected 0/0", in_ready, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || wen !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b wen=%b expected 1/0", in_ready, wen);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_data = 8'h48;
    @(posedge clk); #1;
    total++;
    if (wen !== 1'b1 || write_addr !== 10'd0 || write_data !== 8'h48 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hi_first: wen=%b addr=%0d data=%0h rdy=%b expected 1/0/48/1", wen, write_addr, write_data, in_ready);
    end
    in_data = 8'h69;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (wen !== 1'b1 || write_addr !== 10'd1 || write_data !== 8'h69 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hi_second: wen=%b addr=%0d data=%0h rdy=%b expected 1/1/69/1", wen, write_addr, write_data, in_ready);
    end
    total++;
    if (cursor_col !== 8'd2 || cursor_row !== 8'd0) begin
      bad++;
      $display("FAIL hi_cursor: got (%0d,%0d) expected (0,2)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_linefeed();
    send(8'h61); send(8'h62); send(8'h63);
    send(8'h0A);
    total++;
    if (cursor_row !== 8'd1 || cursor_col !== 8'd5) begin
      bad++;
      $display("FAIL lf_cursor: got (%0d,%0d) expected (1,5)", cursor_row, cursor_col);
    end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (wen !== 1'b1 || write_addr !== 10'(32 + k) || write_data !== 8'h00 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL lf_clear[%0d]: wen=%b addr=%0d data=%0h rdy=%b expected 1/%0d/0/0",
                 k, wen, write_addr, write_data, in_ready, 32 + k);
      end
      @(posedge clk); #1;
    end
    total++;
    if (wen !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL lf_done: wen=%b rdy=%b expected 0/1", wen, in_ready);
    end
  endtask

  task automatic test_wrap();
    send(8'h0D);
    for (int r = 0; r < 14; r++) begin
      send(8'h0A);
      wait_idle();
    end
    total++;
    if (cursor_row !== 8'd15 || cursor_col !== 8'd0) begin
      bad++;
      $display("FAIL wrap_start: got (%0d,%0d) expected (15,0)", cursor_row, cursor_col);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = 8'(8'h41 + i % 26);
      @(posedge clk); #1;
      total++;
      if (wen !== 1'b1 || write_addr !== 10'(480 + i) || write_data !== 8'(8'h41 + i % 26)) begin
        bad++;
        $display("FAIL wrap_char[%0d]: wen=%b addr=%0d data=%0h expected 1/%0d/%0h",
                 i, wen, write_addr, write_data, 480 + i, 8'h41 + i % 26);
      end
    end
    in_valid = 1'b0;
    total++;
    if (cursor_row !== 8'd0 || cursor_col !== 8'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL wrap_cursor: got (%0d,%0d) rdy=%b expected (0,0) rdy=0", cursor_row, cursor_col, in_ready);
    end
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      total++;
      if (wen !== 1'b1 || write_addr !== 10'(k) || write_data !== 8'h00) begin
        bad++;
        $display("FAIL wrap_clear[%0d]: wen=%b addr=%0d data=%0h expected 1/%0d/0", k, wen, write_addr, write_data, k);
      end
    end
    @(posedge clk); #1;
    total++;
    if (wen !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done: wen=%b rdy=%b expected 0/1", wen, in_ready);
    end
  endtask

  task automatic test_backspace();
    send(8'h0A); wait_idle();
    send(8'h0A); wait_idle();
    send(8'h78); send(8'h79); send(8'h7A);
    send(8'h08);
    total++;
    if (wen !== 1'b1 || write_addr !== 10'd66 || write_data !== 8'h00) begin
      bad++;
      $display("FAIL bs_write: wen=%b addr=%0d data=%0h expected 1/66/0", wen, write_addr, write_data);
    end
    total++;
    if (cursor_row !== 8'd2 || cursor_col !== 8'd2) begin
      bad++;
      $display("FAIL bs_cursor: got (%0d,%0d) expected (2,2)", cursor_row, cursor_col);
    end
    send(8'h0D);
    total++;
    if (wen !== 1'b0 || cursor_col !== 8'd0) begin
      bad++;
      $display("FAIL cr: wen=%b col=%0d expected 0/0", wen, cursor_col);
    end
    send(8'h08);
    total++;
    if (wen !== 1'b0 || cursor_row !== 8'd2 || cursor_col !== 8'd0) begin
      bad++;
      $display("FAIL bs_col0: wen=%b cursor=(%0d,%0d) expected 0 (2,0)", wen, cursor_row, cursor_col);
    end
  endtask

  task automatic test_tab();
    send(8'h61); send(8'h62); send(8'h63);
    send(8'h09);
    total++;
    if (wen !== 1'b0 || cursor_col !== 8'd8) begin
      bad++;
      $display("FAIL tab_3: wen=%b col=%0d expected 0/8", wen, cursor_col);
    end
    for (int i = 0; i < 22; i++) send(8'h2E);
    total++;
    if (cursor_col !== 8'd30) begin
      bad++;
      $display("FAIL tab_setup: col=%0d expected 30", cursor_col);
    end
    send(8'h09);
    total++;
    if (wen !== 1'b0 || cursor_col !== 8'd31 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL tab_30: wen=%b col=%0d rdy=%b expected 0/31/1", wen, cursor_col, in_ready);
    end
    send(8'h07);
    total++;
    if (wen !== 1'b0 || cursor_row !== 8'd2 || cursor_col !== 8'd31) begin
      bad++;
      $display("FAIL bel_ignored: wen=%b cursor=(%0d,%0d) expected 0 (2,31)", wen, cursor_row, cursor_col);
    end
  endtask

  task automatic test_formfeed();
    send(8'h0C);
    total++;
    if (cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
      bad++;
      $display("FAIL ff_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col);
    end
    for (int k = 0; k < 512; k++) begin
      total++;
      if (wen !== 1'b1 || write_addr !== 10'(k) || write_data !== 8'h00 || busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ff_clear[%0d]: wen=%b addr=%0d data=%0h busy=%b rdy=%b expected 1/%0d/0/1/0",
                 k, wen, write_addr, write_data, busy, in_ready, k);
      end
      @(posedge clk); #1;
    end
    total++;
    if (wen !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ff_done: wen=%b busy=%b rdy=%b expected 0/0/1", wen, busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    send(8'h0A);
    in_valid = 1'b1; in_data = 8'h5A;
    for (int k = 0; k < 32; k++) begin
      total++;
      if (wen !== 1'b1 || write_addr !== 10'(32 + k) || write_data !== 8'h00) begin
        bad++;
        $display("FAIL stall_clear[%0d]: wen=%b addr=%0d data=%0h expected 1/%0d/0", k, wen, write_addr, write_data, 32 + k);
      end
      @(posedge clk); #1;
    end
    total++;
    if (wen !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_ready: wen=%b rdy=%b expected 0/1", wen, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (wen !== 1'b1 || write_addr !== 10'd32 || write_data !== 8'h5A || cursor_col !== 8'd1) begin
      bad++;
      $display("FAIL stall_accept: wen=%b addr=%0d data=%0h col=%0d expected 1/32/5a/1", wen, write_addr, write_data, cursor_col);
    end
  endtask

  task automatic test_reset_mid_clear();
    int extra;
    send(8'h0C);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if (wen !== 1'b1 || write_addr !== 10'd9) begin
      bad++;
      $display("FAIL midclr_pre: wen=%b addr=%0d expected 1/9", wen, write_addr);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (wen !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midclr_abort: wen=%b rdy=%b busy=%b expected 0/0/0", wen, in_ready, busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || cursor_row !== 8'd0 || cursor_col !== 8'd0) begin
      bad++;
      $display("FAIL midclr_release: rdy=%b cursor=(%0d,%0d) expected 1 (0,0)", in_ready, cursor_row, cursor_col);
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      if (wen === 1'b1) extra++;
      @(posedge clk); #1;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL midclr_nowrites: got %0d writes expected 0", extra);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_back_to_back();
    test_linefeed();
    test_wrap();
    test_backspace();
    test_tab();
    test_formfeed();
    test_backpressure();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream feeder of the HDMI text-overlay stage: turns a byte stream of ASCII characters and control codes, e.g. from a CPU MMIO port, into single-byte writes (wen/write_addr/write_data) into the overlay's character buffer.
- Maintains a cursor and handles CR, LF, backspace, tab, auto-wrap and form-feed.
- Clears rows and the screen with multi-cycle fill sequences.

Parameters:
- COLS, 32, characters per row; COLS*ROWS <= 1024.
- ROWS, 16, rows on screen.
- FILL_CHAR, 8'h00, byte written by clear operations and backspace.
- TAB_STOP, 8, tab alignment; must be a power of two.

Ports:
- clk  in  1  system clock, the same domain as the overlay's write port.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  character byte available.
- in_data  in  8  character byte.
- in_ready  out  1  block accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- wen  out  1  buffer write strobe, one cycle per cell.
- write_addr  out  10  cell address = row*COLS + col.
- write_data  out  8  byte to store.
- cursor_col  out  8  current column, 0..COLS-1.
- cursor_row  out  8  current row, 0..ROWS-1.
- busy  out  1  high while in CLR_ROW or CLR_SCR.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE; wen=0; write_addr=0; write_data=0.
  - cursor_col=0; cursor_row=0; in_ready=0 while reset is held.
  - First cycle after release: in_ready=1.
- All outputs are registered.
- in_ready = (state==IDLE) and not reset.
- Back-to-back bytes are accepted every cycle while IDLE.
- Latency: byte accepted at edge N produces its write (if any) with wen=1 in the cycle after edge N, i.e. visible at N+1. The cursor updates at the same edge.
- States: IDLE, CLR_ROW, CLR_SCR.
- IDLE, on accept:
  - 0x20..0x7E: write byte at (row,col).
    - If col<COLS-1: col+1.
    - Else: col=0, row=(row+1) mod ROWS, enter CLR_ROW for the new row.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col unchanged, row=(row+1) mod ROWS, enter CLR_ROW for the new row. Wrap from ROWS-1 goes to row 0.
  - 0x08 (BS):
    - If col>0: col-1 and write FILL_CHAR at the new position.
    - If col==0: no move, no write.
  - 0x09 (TAB): col = next multiple of TAB_STOP, saturated at COLS-1; no write.
  - 0x0C (FF): cursor to (0,0), enter CLR_SCR.
  - Any other byte: ignored, no write, cursor unchanged.
- CLR_ROW:
  - Internal counter c runs 0..COLS-1, one write per cycle: addr=row*COLS+c, data=FILL_CHAR.
  - The first clear write is in the cycle after the triggering accept. If the trigger was a printable, its own write occurs first and the clear follows, so the clear starts one cycle later.
  - Returns to IDLE after the c==COLS-1 write.
  - in_ready=0 throughout.
  - Total busy time = COLS cycles of writes.
- CLR_SCR:
  - Counter 0..COLS*ROWS-1, one write per cycle of FILL_CHAR at addr=counter.
  - Then IDLE; in_ready=0 throughout.
- Address arithmetic: row*COLS computed at full width, truncated to 10 bits; the COLS*ROWS<=1024 constraint guarantees no overflow.
- wen is never high for more than one cycle per cell; the same address is never written twice in one clear.
- An in_valid held high while in_ready=0 is not consumed; in_data must remain stable until the transfer.
- Reset mid-clear aborts immediately, and no further wen is issued. The partially cleared region is left as is.

Test Plan:
- Reset then bytes "Hi" on consecutive cycles -> wen pulses at addr 0 data 0x48, then addr 1 data 0x69; cursor_col=2, in_ready stays 1.
- With cursor at (0,5), send 0x0A -> cursor (1,5); 32 consecutive writes of 0x00 to addr 32..63; in_ready=0 for those 32 cycles, then 1.
- Write 32 printable bytes starting at (15,0) -> last char at addr 511; cursor wraps to (0,0); then 32 clear writes at addr 0..31.
- Cursor at (2,3), send 0x08 -> write 0x00 at addr 66, cursor (2,2); at col 0, 0x08 -> no wen, cursor unchanged.
- Send 0x0C -> cursor (0,0); exactly 512 writes, addr 0..511 in order; busy high for 512 cycles.
- Assert reset during the 10th cycle of a CLR_SCR -> wen=0 immediately; after release in_ready=1, cursor (0,0), no further writes.
- TAB from col 3 -> col 8; TAB from col 30 -> col 31; 0x07 -> no write, cursor unchanged.
